// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Access size is funct3[1:0]; funct3[2] selects zero-extension on loads.
package mem_stage_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } acc_size_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (acc_size_e'(size))
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (acc_size_e'(size))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment: store lane shift/strobes and load shift/extension.
// Purely combinational; also usable by the fetch path for halfword extraction.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        st_size,
  input  logic [2:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  input  logic [2:0]        ld_funct3,
  input  logic [2:0]        ld_off,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] st_lane_data,
  output logic [7:0]        st_strb,
  output logic [DATA_W-1:0] ld_ext
);

  logic [DATA_W-1:0] raw;
  logic              sext;

  always_comb begin
    st_lane_data = st_data << {st_off, 3'b000};
    st_strb      = size_mask(st_size) << st_off;
  end

  always_comb begin
    raw  = ld_raw >> {ld_off, 3'b000};
    sext = ~ld_funct3[2];
    case (acc_size_e'(ld_funct3[1:0]))
      SZ_B:    ld_ext = {{(DATA_W-8){sext & raw[7]}}, raw[7:0]};
      SZ_H:    ld_ext = {{(DATA_W-16){sext & raw[15]}}, raw[15:0]};
      SZ_W:    ld_ext = {{(DATA_W-32){sext & raw[31]}}, raw[31:0]};
      default: ld_ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one bus access per valid load/store, stalling
// the pipeline until the response returns, with flush/drain handling.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic              mem_ren_i,
  input  logic              mem_wen_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              stall_mem_i,
  input  logic              flush_mem_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [7:0]        bus_wstrb_o,
  input  logic              bus_ready_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_err_i,
  output logic              ram_stall_mem_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              mem_done_o,
  output logic              misalign_o,
  output logic              access_fault_o
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              ren_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;
  logic [2:0]        funct3_q;
  logic [2:0]        off_q;
  logic              err_q;
  logic              first_q;
  logic              consumed_q;
  logic [DATA_W-1:0] load_q;

  logic              is_mem;
  logic              mis;
  logic              acc;
  logic              issue;
  logic              stall_raw;
  logic [DATA_W-1:0] st_lane_data;
  logic [7:0]        st_strb;
  logic [DATA_W-1:0] ld_ext;

  mem_stage_lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_size      (mem_funct3_i[1:0]),
    .st_off       (mem_addr_i[2:0]),
    .st_data      (mem_wdata_i),
    .ld_funct3    (funct3_q),
    .ld_off       (off_q),
    .ld_raw       (bus_rdata_i),
    .st_lane_data (st_lane_data),
    .st_strb      (st_strb),
    .ld_ext       (ld_ext)
  );

  always_comb begin
    is_mem = mem_valid_i & (mem_ren_i | mem_wen_i);
    mis    = is_mem & misaligned(mem_funct3_i[1:0], mem_addr_i[2:0]);
    acc    = is_mem & ~mis & ~flush_mem_i & ~consumed_q;
    issue  = acc & ((state_q == ST_IDLE) | ((state_q == ST_DRAIN) & bus_rvalid_i));
    case (state_q)
      ST_REQ, ST_WAIT: stall_raw = 1'b1;
      ST_IDLE, ST_DRAIN: stall_raw = acc;
      default: stall_raw = 1'b0;
    endcase
  end

  // Stall and misalign follow the inputs combinationally; reset forces them low too.
  assign ram_stall_mem_o = stall_raw & ~rst;
  assign misalign_o      = mis & ~rst;
  assign bus_req_o       = (state_q == ST_REQ) & ~flush_mem_i;
  assign bus_we_o        = we_q;
  assign bus_addr_o      = addr_q;
  assign bus_wdata_o     = wdata_q;
  assign bus_wstrb_o     = wstrb_q;
  assign load_data_o     = load_q;
  assign mem_done_o      = (state_q == ST_DONE);
  assign access_fault_o  = (state_q == ST_DONE) & err_q & first_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      ren_q      <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
      consumed_q <= 1'b0;
      load_q     <= '0;
    end else begin
      first_q <= 1'b0;
      if (issue) begin
        addr_q   <= {mem_addr_i[ADDR_W-1:3], 3'b000};
        we_q     <= mem_wen_i;
        ren_q    <= mem_ren_i & ~mem_wen_i;
        wdata_q  <= st_lane_data;
        wstrb_q  <= st_strb;
        funct3_q <= mem_funct3_i;
        off_q    <= mem_addr_i[2:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (acc) state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (flush_mem_i)      state_q <= ST_IDLE;
          else if (bus_ready_i) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A response arriving with the flush retires the access outright.
          if (flush_mem_i) begin
            state_q <= bus_rvalid_i ? ST_IDLE : ST_DRAIN;
          end else if (bus_rvalid_i) begin
            state_q    <= ST_DONE;
            err_q      <= bus_err_i;
            first_q    <= 1'b1;
            consumed_q <= 1'b1;
            load_q     <= (bus_err_i | ~ren_q) ? '0 : ld_ext;
          end
        end
        ST_DONE: begin
          if (flush_mem_i | ~stall_mem_i) begin
            state_q    <= ST_IDLE;
            consumed_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (bus_rvalid_i) state_q <= acc ? ST_REQ : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
